// File: rtl/ft_boot_recovery_ctrl.sv
// Boot / fault-recovery sequencer: IMEM load, BIST window, flush, then RUN with fault triage.
// Optional macro FTC_SERR_RELOAD_EN: a single-bit error count >= SERR_LIMIT in RUN forces a reload.
module ft_boot_recovery_ctrl #(
    parameter int unsigned IMEM_WORDS   = 1024,
    parameter int unsigned IMEM_BASE    = 0,
    parameter int unsigned BIST_CYCLES  = 64,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned MAX_RELOADS  = 3,
    parameter int unsigned SERR_LIMIT   = 16,
    localparam int unsigned RCW = (MAX_RELOADS > 0) ? $clog2(MAX_RELOADS + 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_valid,
    output logic           ld_ready,
    input  logic [31:0]    ld_data,
    input  logic           ld_last,
    output logic           imem_we,
    output logic [31:0]    imem_waddr,
    output logic [31:0]    imem_wdata,
    output logic           loader_done,
    output logic           pipe_rst,
    output logic           test_en,
    input  logic           s_err_imem,
    input  logic           s_err_dmem,
    input  logic           d_err_imem,
    input  logic           d_err_dmem,
    input  logic           hardware_fault_flag,
    input  logic           mux_error_flag,
    output logic [2:0]     state,
    output logic [15:0]    serr_count,
    output logic [RCW-1:0] reload_count,
    output logic           load_ovf,
    output logic           fatal
);

    localparam int unsigned IDXW   = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int unsigned TMAX   = (BIST_CYCLES > FLUSH_CYCLES) ? BIST_CYCLES : FLUSH_CYCLES;
    localparam int unsigned TMW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_BIST  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t          cur, nxt;
    logic [IDXW-1:0] idx;
    logic [TMW-1:0]  tmr;
    logic            hs, idx_end, serr_evt, reload_req, can_reload;
    logic [16:0]     serr_sum;

    assign hs         = ld_valid & ld_ready;
    assign idx_end    = (idx == IDXW'(IMEM_WORDS - 1));
    assign can_reload = (reload_count != RCW'(MAX_RELOADS));
    assign state      = cur;

`ifdef FTC_SERR_RELOAD_EN
    assign serr_evt = (serr_count >= 16'(SERR_LIMIT));
`else
    assign serr_evt = 1'b0;
`endif

    // A double-bit IMEM error outranks the error-count trigger; both share the reload budget.
    assign reload_req = (cur == S_RUN) && (d_err_imem || serr_evt);

    always_ff @(posedge clk) begin
        if (rst) cur <= S_LOAD;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_LOAD:  if (hs && (ld_last || idx_end)) nxt = S_BIST;
            S_BIST: begin
                if (hardware_fault_flag)                   nxt = S_FAIL;
                else if (tmr == TMW'(BIST_CYCLES - 1))     nxt = S_FLUSH;
            end
            S_FLUSH: if (tmr == TMW'(FLUSH_CYCLES - 1))   nxt = S_RUN;
            S_RUN: begin
                if (reload_req)                            nxt = can_reload ? S_LOAD : S_FAIL;
                else if (hardware_fault_flag)              nxt = S_BIST;
                else if (d_err_dmem || mux_error_flag)     nxt = S_FLUSH;
            end
            S_FAIL:  nxt = S_FAIL;
            default: nxt = S_FAIL;
        endcase
    end

    always_comb begin
        ld_ready    = 1'b0;
        pipe_rst    = 1'b1;
        test_en     = 1'b0;
        loader_done = 1'b0;
        fatal       = 1'b0;
        case (cur)
            S_LOAD:  ld_ready = 1'b1;
            S_BIST: begin
                pipe_rst = 1'b0;
                test_en  = 1'b1;
            end
            S_FLUSH: loader_done = 1'b1;
            S_RUN: begin
                pipe_rst    = 1'b0;
                loader_done = 1'b1;
            end
            S_FAIL:  fatal = 1'b1;
            default: fatal = 1'b1;
        endcase
    end

    assign serr_sum = {1'b0, serr_count} + 17'(s_err_imem) + 17'(s_err_dmem);

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_waddr   <= 32'(IMEM_BASE);
            imem_wdata   <= '0;
            idx          <= '0;
            tmr          <= '0;
            serr_count   <= '0;
            reload_count <= '0;
            load_ovf     <= 1'b0;
        end else begin
            imem_we <= hs;
            if (hs) begin
                imem_waddr <= 32'(IMEM_BASE) + (32'(idx) << 2);
                imem_wdata <= ld_data;
                idx        <= (ld_last || idx_end) ? '0 : idx + 1'b1;
                if (idx_end && !ld_last) load_ovf <= 1'b1;
            end
            // Timer restarts on every state change so each window counts from zero.
            if (nxt != cur)                            tmr <= '0;
            else if (cur == S_BIST || cur == S_FLUSH)  tmr <= tmr + 1'b1;
            if (reload_req && can_reload) reload_count <= reload_count + 1'b1;
            if (cur == S_RUN && !d_err_imem && serr_evt) serr_count <= '0;
            else serr_count <= serr_sum[16] ? 16'hFFFF : serr_sum[15:0];
        end
    end

endmodule

// File: tb/tb_ft_boot_recovery_ctrl.sv
// Directed bench for ft_boot_recovery_ctrl: table of RUN-state fault vectors plus
// hand-written boot, reload, saturation and reset sequences.
module tb_ft_boot_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready, ld_last;
    logic [31:0] ld_data;
    logic        imem_we;
    logic [31:0] imem_waddr, imem_wdata;
    logic        loader_done, pipe_rst, test_en;
    logic        s_err_imem, s_err_dmem, d_err_imem, d_err_dmem;
    logic        hardware_fault_flag, mux_error_flag;
    logic [2:0]  state;
    logic [15:0] serr_count;
    logic [1:0]  reload_count;
    logic        load_ovf, fatal;

    int total = 0;
    int bad   = 0;

    ft_boot_recovery_ctrl dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .loader_done(loader_done), .pipe_rst(pipe_rst), .test_en(test_en),
        .s_err_imem(s_err_imem), .s_err_dmem(s_err_dmem),
        .d_err_imem(d_err_imem), .d_err_dmem(d_err_dmem),
        .hardware_fault_flag(hardware_fault_flag), .mux_error_flag(mux_error_flag),
        .state(state), .serr_count(serr_count), .reload_count(reload_count),
        .load_ovf(load_ovf), .fatal(fatal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d_imem, hw, d_dmem, mux, s_imem, s_dmem;
        logic [2:0] exp_state;
        logic [1:0] exp_rel;
        logic [15:0] exp_serr;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read at the same offset.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ld_valid = 0; ld_last = 0; ld_data = 0;
        s_err_imem = 0; s_err_dmem = 0; d_err_imem = 0; d_err_dmem = 0;
        hardware_fault_flag = 0; mux_error_flag = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 1);
        chk({tag, "_imem_we"}, 32'(imem_we), 0);
        chk({tag, "_waddr"}, imem_waddr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_loader_done"}, 32'(loader_done), 0);
        chk({tag, "_pipe_rst"}, 32'(pipe_rst), 1);
        chk({tag, "_test_en"}, 32'(test_en), 0);
        chk({tag, "_serr"}, 32'(serr_count), 0);
        chk({tag, "_reload"}, 32'(reload_count), 0);
        chk({tag, "_ovf"}, 32'(load_ovf), 0);
        chk({tag, "_fatal"}, 32'(fatal), 0);
    endtask

    task automatic load_words(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1;
            ld_data  = 32'hA000_0000 + 32'(i);
            ld_last  = last && (i == n - 1);
            step();
        end
        ld_valid = 0; ld_last = 0;
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(state), 32'(s));
    endtask

    task automatic boot();
        do_reset();
        load_words(1, 1);
        wait_state("boot_to_run", 3'd3, 200);
    endtask

    initial begin
        int n;
        vt[0] = '{0,0,0,0,0,0, 3'd3, 2'd0, 16'd0};
        vt[1] = '{1,0,0,0,0,0, 3'd0, 2'd1, 16'd0};
        vt[2] = '{1,0,0,1,0,0, 3'd0, 2'd1, 16'd0};
        vt[3] = '{1,1,1,0,0,0, 3'd0, 2'd1, 16'd0};
        vt[4] = '{0,1,0,0,0,0, 3'd1, 2'd0, 16'd0};
        vt[5] = '{0,1,1,1,0,0, 3'd1, 2'd0, 16'd0};
        vt[6] = '{0,0,1,0,0,0, 3'd2, 2'd0, 16'd0};
        vt[7] = '{0,0,0,1,0,0, 3'd2, 2'd0, 16'd0};
        vt[8] = '{0,0,0,0,1,1, 3'd3, 2'd0, 16'd2};

        // Boot: 4 words, write addresses, BIST and FLUSH window lengths.
        do_reset();
        chk_reset_vals("rst");
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = 32'hC0DE_0000 + 32'(i); ld_last = (i == 3);
            step();
            chk("boot_we", 32'(imem_we), 1);
            chk("boot_addr", imem_waddr, 32'(4 * i));
            chk("boot_data", imem_wdata, 32'hC0DE_0000 + 32'(i));
        end
        ld_valid = 0; ld_last = 0;
        chk("boot_bist_state", 32'(state), 1);
        chk("boot_ready_drop", 32'(ld_ready), 0);
        n = 0;
        while (test_en === 1'b1 && n < 300) begin
            if (n == 1) chk("boot_we_off", 32'(imem_we), 0);
            n++;
            step();
        end
        chk("bist_len", n, 64);
        chk("flush_state", 32'(state), 2);
        n = 0;
        while (pipe_rst === 1'b1 && n < 300) begin n++; step(); end
        chk("flush_len", n, 4);
        chk("run_state", 32'(state), 3);
        chk("run_loader_done", 32'(loader_done), 1);

        // Fault during BIST is terminal until reset.
        do_reset();
        load_words(1, 1);
        for (int i = 0; i < 10; i++) step();
        hardware_fault_flag = 1;
        step();
        hardware_fault_flag = 0;
        chk("bist_fault_state", 32'(state), 4);
        chk("bist_fault_fatal", 32'(fatal), 1);
        for (int i = 0; i < 5; i++) step();
        chk("fail_hold", 32'(state), 4);
        chk("fail_pipe_rst", 32'(pipe_rst), 1);
        chk("fail_ld_ready", 32'(ld_ready), 0);
        do_reset();
        chk("fail_cleared", 32'(state), 0);

        // RUN-state event priority table.
        for (int v = 0; v < 9; v++) begin
            boot();
            d_err_imem = vt[v].d_imem; hardware_fault_flag = vt[v].hw;
            d_err_dmem = vt[v].d_dmem; mux_error_flag = vt[v].mux;
            s_err_imem = vt[v].s_imem; s_err_dmem = vt[v].s_dmem;
            step();
            clr_in();
            chk($sformatf("vec%0d_state", v), 32'(state), 32'(vt[v].exp_state));
            chk($sformatf("vec%0d_reload", v), 32'(reload_count), 32'(vt[v].exp_rel));
            chk($sformatf("vec%0d_serr", v), 32'(serr_count), 32'(vt[v].exp_serr));
            chk($sformatf("vec%0d_done", v), 32'(loader_done),
                32'(vt[v].exp_state == 3'd2 || vt[v].exp_state == 3'd3));
        end

        // Reload budget: three reloads, fourth double-bit error is fatal.
        boot();
        for (int k = 1; k <= 4; k++) begin
            d_err_imem = 1;
            step();
            d_err_imem = 0;
            if (k < 4) begin
                chk("reload_state", 32'(state), 0);
                chk("reload_cnt", 32'(reload_count), 32'(k));
                load_words(2, 1);
                wait_state("reload_run", 3'd3, 200);
            end else begin
                chk("reload_fail", 32'(state), 4);
                chk("reload_fatal", 32'(fatal), 1);
                chk("reload_cnt_max", 32'(reload_count), 3);
            end
        end

        // d_err_dmem alone: flush then back to RUN.
        boot();
        d_err_dmem = 1;
        step();
        d_err_dmem = 0;
        chk("dmem_flush", 32'(state), 2);
        n = 0;
        while (pipe_rst === 1'b1 && n < 50) begin n++; step(); end
        chk("dmem_flush_len", n, 4);
        chk("dmem_back_run", 32'(state), 3);

        // Single-bit error counter saturates without wrapping.
        do_reset();
        s_err_imem = 1; s_err_dmem = 1;
        for (int i = 0; i < 32767; i++) step();
        chk("serr_near_sat", 32'(serr_count), 32'hFFFE);
        for (int i = 0; i < 40000 - 32767; i++) step();
        chk("serr_sat", 32'(serr_count), 32'hFFFF);
        chk("serr_no_state_chg", 32'(state), 0);
        clr_in();

`ifdef FTC_SERR_RELOAD_EN
        boot();
        s_err_imem = 1; s_err_dmem = 1;
        for (int i = 0; i < 8; i++) step();
        clr_in();
        chk("serr_cnt16", 32'(serr_count), 16);
        step();
        chk("serr_reload_state", 32'(state), 0);
        chk("serr_cleared", 32'(serr_count), 0);
        chk("serr_reload_cnt", 32'(reload_count), 1);
`endif

        // Reset mid-load, then restart at base address.
        do_reset();
        load_words(2, 0);
        rst = 1;
        step();
        rst = 0;
        chk_reset_vals("midload");
        load_words(1, 0);
        chk("restart_addr", imem_waddr, 0);
        chk("restart_we", 32'(imem_we), 1);

        // Overflow: 1024 words without ld_last.
        do_reset();
        load_words(1023, 0);
        chk("ovf_pre_state", 32'(state), 0);
        chk("ovf_pre_flag", 32'(load_ovf), 0);
        load_words(1, 0);
        chk("ovf_state", 32'(state), 1);
        chk("ovf_flag", 32'(load_ovf), 1);
        chk("ovf_addr", imem_waddr, 32'd4092);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
